// File: rtl/nn_window_gen.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift register
// turn a raster pixel stream into every fully populated valid-convolution window.
module nn_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  localparam int CW = ($clog2(IMG_W) > 1) ? $clog2(IMG_W) : 1,
  localparam int RW = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [8:0]    pix_in,
  output logic [80:0]   win_flat,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic          last_col, last_row, win_ok, accept;

  // in_sof overrides the running position so a restart needs no extra cycle
  assign cur_col  = in_sof ? '0 : col_cnt;
  assign cur_row  = in_sof ? '0 : row_cnt;
  assign last_col = (cur_col == COL_LAST);
  assign last_row = (cur_row == ROW_LAST);
  assign win_ok   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign accept   = in_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_cnt <= cur_col + CW'(1);
        row_cnt <= cur_row;
      end
    end
  end

  // Line buffers are read combinationally so the column shifts in on the accept edge
  logic [8:0] lb_old [IMG_W];
  logic [8:0] lb_mid [IMG_W];
  logic [8:0] old_rd, mid_rd;
  logic [8:0] new_col [3];

  assign old_rd     = lb_old[cur_col];
  assign mid_rd     = lb_mid[cur_col];
  assign new_col[0] = old_rd;
  assign new_col[1] = mid_rd;
  assign new_col[2] = pix_in;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[cur_col] <= mid_rd;
      lb_mid[cur_col] <= pix_in;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic [8:0] c0_reg, c1_reg, c2_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          c0_reg <= '0;
          c1_reg <= '0;
          c2_reg <= '0;
        end else if (in_valid) begin
          c0_reg <= c1_reg;
          c1_reg <= c2_reg;
          c2_reg <= new_col[gi];
        end
      end

      assign win_flat[gi*27 +: 9]      = c0_reg;
      assign win_flat[gi*27 + 9 +: 9]  = c1_reg;
      assign win_flat[gi*27 + 18 +: 9] = c2_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= in_valid && win_ok;
      frame_done <= in_valid && last_row && last_col;
      if (in_valid && win_ok) begin
        win_row <= cur_row - RW'(2);
        win_col <= cur_col - CW'(2);
      end
    end
  end

endmodule

// File: tb/tb_nn_window_gen.sv
// Directed bench for nn_window_gen: 4x4 instance for window order, bubbles,
// extremes, restarts and reset; 28x28 instance for back-to-back frames.
module tb_nn_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0;
  logic [8:0]  pix_in = '0;
  logic [80:0] win_flat;
  logic        win_valid, frame_done;
  logic [1:0]  win_row, win_col;

  logic        b_in_valid = 1'b0, b_in_sof = 1'b0;
  logic [8:0]  b_pix_in = '0;
  logic [80:0] b_win_flat;
  logic        b_win_valid, b_frame_done;
  logic [4:0]  b_win_row, b_win_col;

  nn_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .pix_in(pix_in),
    .win_flat(win_flat), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
  );

  nn_window_gen #(.IMG_W(28), .IMG_H(28)) dut_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_sof(b_in_sof), .pix_in(b_pix_in),
    .win_flat(b_win_flat), .win_valid(b_win_valid), .win_row(b_win_row),
    .win_col(b_win_col), .frame_done(b_frame_done)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] img [4][4];

  typedef struct packed {
    logic [4:0]  after;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        fd;
    logic [80:0] flat;
  } vec_t;
  vec_t tbl [4];

  task automatic chk_bit(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [80:0] a, input logic [80:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [80:0] pk9(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
    int a [9];
    logic [80:0] f;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    f = '0;
    for (int k = 0; k < 9; k++) f[k*9 +: 9] = 9'(a[k]);
    return f;
  endfunction

  function automatic logic [80:0] model_flat(input int r0, input int c0);
    logic [80:0] f;
    f = '0;
    for (int k = 0; k < 9; k++) f[k*9 +: 9] = img[r0 + k/3][c0 + k%3];
    return f;
  endfunction

  function automatic logic [8:0] val(input int kind, input int i);
    if (kind == 0) return 9'(i);
    if (kind == 1) return (i % 2 == 1) ? 9'h0FF : 9'h100;
    return 9'(100 + i);
  endfunction

  function automatic logic [8:0] bval(input int f, input int r, input int c);
    return 9'((r*28 + c)*3 + f*5);
  endfunction

  function automatic logic [80:0] bflat(input int f, input int r0, input int c0);
    logic [80:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*9 +: 9] = bval(f, r0 + k/3, c0 + k%3);
    return w;
  endfunction

  task automatic step(input logic v, input logic sof, input logic [8:0] p);
    @(negedge clk);
    in_valid = v; in_sof = sof; pix_in = p;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic [8:0] p);
    @(negedge clk);
    b_in_valid = v; b_in_sof = 1'b0; b_pix_in = p;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string nm);
    chk_vec({nm, " flat"}, win_flat, '0);
    chk_bit({nm, " valid"}, win_valid, 1'b0);
    chk_int({nm, " row"}, int'(win_row), 0);
    chk_int({nm, " col"}, int'(win_col), 0);
    chk_bit({nm, " fd"}, frame_done, 1'b0);
  endtask

  task automatic chk_win(input string nm, input bit ev, input int r0, input int c0, input bit efd);
    chk_bit({nm, " valid"}, win_valid, ev);
    chk_bit({nm, " fd"}, frame_done, efd);
    if (ev) begin
      chk_vec({nm, " flat"}, win_flat, model_flat(r0, c0));
      chk_int({nm, " row"}, int'(win_row), r0);
      chk_int({nm, " col"}, int'(win_col), c0);
    end
  endtask

  task automatic run_frame(input string nm, input int kind, input int maxgap,
                           input bit sof_first, input int npix, output int nwin);
    nwin = 0;
    for (int i = 0; i < npix; i++) begin
      int r, c, gaps;
      r = i / 4;
      c = i % 4;
      gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 1)) : 0;
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 1'b0, 9'h1AA);
        chk_bit({nm, " gap valid"}, win_valid, 1'b0);
        chk_bit({nm, " gap fd"}, frame_done, 1'b0);
      end
      img[r][c] = val(kind, i);
      step(1'b1, sof_first && (i == 0), img[r][c]);
      if (win_valid) nwin++;
      $display("%s px %0d (%0d,%0d) valid=%0b fd=%0b", nm, i, r, c, win_valid, frame_done);
      chk_win(nm, (r >= 2) && (c >= 2), r - 2, c - 2, i == 15);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, j, mism, fdc;
    int nwb [2];

    tbl[0] = {5'd10, 2'd0, 2'd0, 1'b0, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
    tbl[1] = {5'd11, 2'd0, 2'd1, 1'b0, pk9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    tbl[2] = {5'd14, 2'd1, 2'd0, 1'b0, pk9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
    tbl[3] = {5'd15, 2'd1, 2'd1, 1'b1, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    chk_bit("big reset valid", b_win_valid, 1'b0);
    chk_vec("big reset flat", b_win_flat, '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic window order from the hand-computed table
    j = 0;
    nw = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 9'(i));
      if (win_valid) nw++;
      $display("basic px %0d valid=%0b row=%0d col=%0d fd=%0b", i, win_valid, win_row, win_col, frame_done);
      if (j < 4 && int'(tbl[j].after) == i) begin
        chk_bit("basic valid", win_valid, 1'b1);
        chk_vec("basic flat", win_flat, tbl[j].flat);
        chk_int("basic row", int'(win_row), int'(tbl[j].row));
        chk_int("basic col", int'(win_col), int'(tbl[j].col));
        chk_bit("basic fd", frame_done, tbl[j].fd);
        j++;
      end else begin
        chk_bit("basic idle valid", win_valid, 1'b0);
        chk_bit("basic idle fd", frame_done, 1'b0);
      end
    end
    chk_int("basic count", nw, 4);

    run_frame("bubble", 0, 5, 1'b0, 16, nw);
    chk_int("bubble count", nw, 4);

    run_frame("extreme", 1, 0, 1'b0, 16, nw);
    chk_int("extreme count", nw, 4);

    // Abandon a frame after 7 pixels, restart with in_sof
    run_frame("abort", 0, 0, 1'b0, 7, nw);
    chk_int("abort count", nw, 0);
    run_frame("sof", 2, 0, 1'b1, 11, nw);
    chk_vec("sof first window", win_flat, pk9(100, 101, 102, 104, 105, 106, 108, 109, 110));
    run_frame("sof tail", 2, 0, 1'b0, 0, nw);
    for (int i = 11; i < 16; i++) begin
      img[i/4][i%4] = val(2, i);
      step(1'b1, 1'b0, img[i/4][i%4]);
      $display("sof px %0d valid=%0b fd=%0b", i, win_valid, frame_done);
      chk_win("sof", (i/4 >= 2) && (i%4 >= 2), i/4 - 2, i%4 - 2, i == 15);
    end

    // Reset after pixel 9; rst wins over a simultaneous in_valid
    run_frame("prerst", 0, 0, 1'b0, 10, nw);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; pix_in = 9'd77;
    @(posedge clk); #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    run_frame("postrst", 0, 0, 1'b0, 16, nw);
    chk_int("postrst count", nw, 4);

    // 28x28 back-to-back frames, no in_sof
    mism = 0;
    fdc = 0;
    nwb[0] = 0;
    nwb[1] = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 784; i++) begin
        int r, c;
        bit ev;
        r = i / 28;
        c = i % 28;
        ev = (r >= 2) && (c >= 2);
        step_b(1'b1, bval(f, r, c));
        if (b_win_valid) nwb[f]++;
        if (b_win_valid !== ev) mism++;
        else if (ev) begin
          if (b_win_flat !== bflat(f, r - 2, c - 2) || int'(b_win_row) != r - 2 ||
              int'(b_win_col) != c - 2) mism++;
        end
        if (b_frame_done) begin
          fdc++;
          $display("big frame %0d done at row=%0d col=%0d", f, b_win_row, b_win_col);
          if (i != 783 || int'(b_win_row) != 25 || int'(b_win_col) != 25) mism++;
        end
      end
    end
    step_b(1'b0, 9'd0);
    chk_int("big frame0 windows", nwb[0], 676);
    chk_int("big frame1 windows", nwb[1], 676);
    chk_int("big frame_done pulses", fdc, 2);
    chk_int("big window mismatches", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_window_gen.md
Name: nn_window_gen

Overview:
- Sliding-window generator directly upstream of the conv/norm/FC stage.
- Accepts a raster-order stream of 9-bit signed pixels and buffers the previous two image lines.
- Emits every fully populated 3x3 window (valid convolution, no padding) as an 81-bit flat word.
- The conv stage consumes it as win_flat[idx*9 +: 9], with idx = row*3 + col.

Parameters:
- IMG_W, 28, pixels per line; legal values >= 3.
- IMG_H, 28, lines per frame; legal values >= 3.
- Local CW = max(1, $clog2(IMG_W)).
- Local RW = max(1, $clog2(IMG_H)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  pix_in is valid this cycle; the block always accepts, there is no ready.
- in_sof  in  1  qualified by in_valid; marks the current pixel as frame position (0,0).
- pix_in  in  9  signed pixel.
- win_flat  out  81  3x3 window; idx 0 = top-left (oldest line, oldest column), idx 8 = bottom-right (current pixel).
- win_valid  out  1  win_flat holds a new valid window this cycle.
- win_row  out  RW  row of the window's top-left pixel.
- win_col  out  CW  column of the window's top-left pixel.
- frame_done  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col_cnt=0, row_cnt=0.
  - win_flat=0, win_valid=0, win_row=0, win_col=0, frame_done=0.
  - Line-buffer contents are not reset; they never reach a valid window unwritten.
- Accept: a pixel is accepted on any edge with in_valid=1. Its position (r,c) is (0,0) if in_sof=1, else (row_cnt,col_cnt).
- Line buffers: two IMG_W-entry buffers, lb_old and lb_mid.
  - On accept at column c: read lb_old[c] (pixel r-2,c) and lb_mid[c] (pixel r-1,c).
  - Then write lb_old[c] <= lb_mid[c] and lb_mid[c] <= pix_in.
  - Read-before-write within the same cycle.
- Window shift: on accept, the 3x3 register shifts one column left. The new right column is {lb_old[c], lb_mid[c], pix_in} for rows 0, 1, 2.
- Output register (updated on every edge, rst excepted):
  - win_valid <= accept && r>=2 && c>=2.
  - win_row <= r-2 and win_col <= c-2 when valid; otherwise hold.
  - win_flat is always driven from the shift register.
- Latency: window content and win_valid appear exactly 1 cycle after the accept edge of the bottom-right pixel.
- Row start: columns 0 and 1 of a new row leave stale previous-row columns in the register. These are never flagged valid.
- Counters, on accept with position (r,c):
  - If c=IMG_W-1: col_cnt <= 0, and row_cnt <= (r=IMG_H-1) ? 0 : r+1.
  - Otherwise: col_cnt <= c+1, row_cnt <= r.
  - Wrap-around after the final pixel is automatic; back-to-back frames need no in_sof.
- frame_done <= accept && r=IMG_H-1 && c=IMG_W-1. It coincides with the final win_valid.
- in_valid=0: counters, line buffers and window register hold. win_valid=0 and frame_done=0 next cycle. Bubbles of any length are transparent to window contents.
- in_sof mid-frame: the partial frame is abandoned with no frame_done. The pixel becomes (0,0) and no window is emitted until row 2, column 2 of the new frame. Old line-buffer data is never output as valid.
- rst mid-frame: identical to power-up reset, and the next pixel is (0,0). rst has priority over in_valid on the same edge.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No arithmetic on pixel values; 9-bit two's-complement passes bit-exact.

Test Plan:
- Basic window order: IMG_W=IMG_H=4, pixels 0..15 raster-order, in_valid held high.
  - First win_valid is 1 cycle after pixel 10, with idx0..8 = 0,1,2,4,5,6,8,9,10 and win_row=0, win_col=0.
  - Exactly 4 windows are emitted.
  - Last window = 5,6,7,9,10,11,13,14,15 at (1,1) with frame_done=1.
- Bubbles: same stream with random in_valid=0 gaps of 1–5 cycles.
  - Windows are identical to the no-gap case.
  - win_valid is never asserted in a gap-following cycle unless a pixel was accepted on the preceding edge.
- Sign/extremes: pixels alternating -256 and 255.
  - All nine 9-bit fields are bit-exact; no sign smear across field boundaries.
- Mid-frame in_sof: 4x4, restart with in_sof at pixel 7, then feed a full 16-pixel frame of value 100+i.
  - No frame_done for the aborted frame.
  - First valid window = 100,101,102,104,105,106,108,109,110.
- Reset mid-frame: rst for 1 cycle after pixel 9.
  - All outputs 0 next cycle.
  - A following clean frame produces exactly 4 correct windows.
- Default size, back-to-back: IMG_W=IMG_H=28, two consecutive frames with no in_sof on the second.
  - 676 windows per frame.
  - Exactly 2 frame_done pulses, one at win_row=25, win_col=25 of each frame.
